// File: rtl/misao_mem_bridge_if.sv
// Signal bundle between the MISA-O core port, the bridge and the external req/ack memory bus.
// The bridge connects through the slave modport; the environment drives the master modport.
interface misao_mem_bridge_if #(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 8
);
   logic              core_rd_en;
   logic              core_wr_en;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic [DATA_W-1:0] core_rdata;
   logic              core_ready;
   logic              flush;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              bus_err;

   modport slave (
      input  core_rd_en, core_wr_en, core_addr, core_wdata, flush, mem_rdata, mem_ack,
      output core_rdata, core_ready, mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );

   modport master (
      output core_rd_en, core_wr_en, core_addr, core_wdata, flush, mem_rdata, mem_ack,
      input  core_rdata, core_ready, mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );
endinterface

// File: rtl/misao_mem_bridge.sv
// Byte-wide bridge from the MISA-O memory port to a req/ack bus, with a one-entry read
// buffer that serves the second nibble read of a byte without wait states.
module misao_mem_bridge #(
   parameter int unsigned       ADDR_W   = 15,
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       TIMEOUT  = 15,
   parameter logic [DATA_W-1:0] ERR_DATA = '0
) (
   input logic               clk,
   input logic               rst,
   misao_mem_bridge_if.slave bus
);
   localparam int unsigned      CNT_W    = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                valid_q, valid_d;
   logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
   logic [DATA_W-1:0]   buf_data_q, buf_data_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                flush_pend_q, flush_pend_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                bus_err_q, bus_err_d;
   logic                core_ready_c;

   logic hit_c;
   logic wait_c;
   logic timeout_c;
   logic coherent_c;

   // A flush in the same cycle suppresses the hit so the read goes to the bus.
   assign hit_c      = valid_q && (buf_addr_q == bus.core_addr) && !bus.flush;
   assign wait_c     = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
   assign timeout_c  = wait_c && !bus.mem_ack && (cnt_q == CNT_LAST);
   assign coherent_c = valid_q && (buf_addr_q == mem_addr_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.core_wr_en) begin
               state_d = ST_WR_WAIT;
            end else if (bus.core_rd_en && !hit_c) begin
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT, ST_WR_WAIT: begin
            if (bus.mem_ack || timeout_c) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Per-state outputs and next values of the buffer and bus registers.
   always_comb begin
      core_ready_c = 1'b0;
      valid_d      = valid_q;
      buf_addr_d   = buf_addr_q;
      buf_data_d   = buf_data_q;
      flush_pend_d = flush_pend_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      bus_err_d    = bus_err_q;
      cnt_d        = (wait_c && !bus.mem_ack && !timeout_c) ? cnt_q + CNT_W'(1) : '0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.flush) begin
               valid_d = 1'b0;
            end
            if (bus.core_wr_en) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = bus.core_addr;
               mem_wdata_d = bus.core_wdata;
               if (bus.core_rd_en) begin
                  bus_err_d = 1'b1;
               end
            end else if (bus.core_rd_en) begin
               if (hit_c) begin
                  core_ready_c = 1'b1;
               end else begin
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = bus.core_addr;
               end
            end
         end
         ST_RD_WAIT: begin
            if (bus.flush) begin
               flush_pend_d = 1'b1;
            end
            if (bus.mem_ack) begin
               buf_data_d = bus.mem_rdata;
               buf_addr_d = mem_addr_q;
               valid_d    = 1'b1;
               mem_req_d  = 1'b0;
            end else if (timeout_c) begin
               mem_req_d  = 1'b0;
               bus_err_d  = 1'b1;
               valid_d    = 1'b0;
               buf_data_d = ERR_DATA;
            end
         end
         ST_WR_WAIT: begin
            if (bus.flush) begin
               flush_pend_d = 1'b1;
            end
            if (bus.mem_ack) begin
               if (coherent_c) begin
                  buf_data_d = mem_wdata_q;
               end
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end else if (timeout_c) begin
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               bus_err_d  = 1'b1;
               valid_d    = 1'b0;
               buf_data_d = ERR_DATA;
            end
         end
         ST_RESP: begin
            core_ready_c = 1'b1;
            // A flush seen during the transaction drops whatever the transaction filled.
            if (flush_pend_q || bus.flush) begin
               valid_d = 1'b0;
            end
            flush_pend_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q      <= 1'b0;
         buf_addr_q   <= '0;
         buf_data_q   <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         bus_err_q    <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         buf_addr_q   <= buf_addr_d;
         buf_data_q   <= buf_data_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign bus.core_rdata = buf_data_q;
   assign bus.core_ready = core_ready_c;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.bus_err    = bus_err_q;

endmodule

// File: tb/tb_misao_mem_bridge.sv
// Randomized bench for misao_mem_bridge: a latency-programmable bus memory plus a
// transaction-level model of the memory contents, the read buffer and the error flag.
module tb_misao_mem_bridge;
   localparam int unsigned ADDR_W   = 15;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned TIMEOUT  = 15;
   localparam int unsigned MEM_SZ   = 1 << ADDR_W;
   localparam logic [7:0]  ERR_DATA = 8'h00;

   logic clk;
   logic rst;

   misao_mem_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

   misao_mem_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bif.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   // Bus memory, and the model's own view of what memory should hold.
   logic [7:0] bus_mem [MEM_SZ];
   logic [7:0] m_mem   [MEM_SZ];
   bit                m_valid;
   logic [ADDR_W-1:0] m_addr;
   bit                m_err;

   int lat    = 0;
   bit noack  = 0;
   int rcnt   = 0;

   int                bursts     = 0;
   int                req_cycles = 0;
   bit                prev_req   = 0;
   logic              cap_we;
   logic [ADDR_W-1:0] cap_addr;
   logic [7:0]        cap_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always #5 clk = ~clk;

   // Memory slave: acks after `lat` cycles of request, or never when noack is set.
   always @(negedge clk) begin
      if (bif.mem_req && !noack) begin
         if (rcnt == lat) begin
            bif.mem_ack = 1'b1;
            if (bif.mem_we) bus_mem[bif.mem_addr] = bif.mem_wdata;
            else            bif.mem_rdata = bus_mem[bif.mem_addr];
            rcnt = 0;
         end else begin
            bif.mem_ack = 1'b0;
            rcnt++;
         end
      end else begin
         bif.mem_ack = 1'b0;
         rcnt = 0;
      end
   end

   // Bus monitor: counts request bursts and records the first cycle of each.
   always @(negedge clk) begin
      if (bif.mem_req) begin
         if (!prev_req) begin
            bursts++;
            req_cycles = 1;
            cap_we    = bif.mem_we;
            cap_addr  = bif.mem_addr;
            cap_wdata = bif.mem_wdata;
         end else begin
            req_cycles++;
         end
      end
      prev_req = bif.mem_req;
   end

   task automatic access(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [7:0] wd, input bit fl, input int l, input bit na);
      bit         hit;
      int         exp_cyc;
      int         cyc;
      int         b0;
      logic [7:0] exp_rd;
      logic [7:0] got_rd;
      hit = rd && !wr && !fl && m_valid && (m_addr == a);
      exp_cyc = hit ? 0 : (na ? int'(TIMEOUT) + 1 : l + 2);
      @(negedge clk);
      lat = l;
      noack = na;
      bif.core_rd_en = rd;
      bif.core_wr_en = wr;
      bif.core_addr  = a;
      bif.core_wdata = wd;
      bif.flush      = fl;
      b0 = bursts;
      #1;
      cyc = 0;
      while (!bif.core_ready && cyc < 100) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      got_rd = bif.core_rdata;

      exp_rd = ERR_DATA;
      if (wr) begin
         if (!na) m_mem[a] = wd;
         else begin m_valid = 0; m_err = 1; end
         if (rd) m_err = 1;
      end else if (!hit) begin
         if (na) begin m_valid = 0; m_err = 1; end
         else begin m_valid = 1; m_addr = a; exp_rd = m_mem[a]; end
      end else begin
         exp_rd = m_mem[a];
      end
      if (fl) m_valid = 0;

      chk("latency", 32'(cyc), 32'(exp_cyc));
      if (rd && !wr) chk("core_rdata", 32'(got_rd), 32'(exp_rd));
      chk("bus_bursts", 32'(bursts - b0), hit ? 32'd0 : 32'd1);
      if (!hit && bursts != b0) begin
         chk("mem_we", 32'(cap_we), 32'(wr));
         chk("mem_addr", 32'(cap_addr), 32'(a));
         if (wr) chk("mem_wdata", 32'(cap_wdata), 32'(wd));
         if (na) chk("req_cycles", 32'(req_cycles), 32'(TIMEOUT));
      end
      chk("bus_err", 32'(bif.bus_err), 32'(m_err));

      @(negedge clk);
      bif.core_rd_en = 1'b0;
      bif.core_wr_en = 1'b0;
      bif.flush      = 1'b0;
      noack          = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      m_valid = 0;
      m_err   = 0;
      m_addr  = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b0;
      bif.core_rd_en = 1'b0;
      bif.core_wr_en = 1'b0;
      bif.core_addr  = '0;
      bif.core_wdata = '0;
      bif.flush      = 1'b0;
      bif.mem_ack    = 1'b0;
      bif.mem_rdata  = '0;
      for (int i = 0; i < int'(MEM_SZ); i++) begin
         bus_mem[i] = 8'($urandom);
         m_mem[i]   = bus_mem[i];
      end
      bus_mem[1] = 8'h35;
      m_mem[1]   = 8'h35;
      m_valid = 0;
      m_err   = 0;
      m_addr  = '0;

      #12;
      chk("rst_mem_req", 32'(bif.mem_req), 32'd0);
      chk("rst_core_ready", 32'(bif.core_ready), 32'd0);
      chk("rst_core_rdata", 32'(bif.core_rdata), 32'd0);
      chk("rst_bus_err", 32'(bif.bus_err), 32'd0);
      chk("rst_mem_addr", 32'(bif.mem_addr), 32'd0);
      rst = 1'b1;

      // Nibble-pair read: miss with bus latency 2, then a zero-wait hit.
      access(1, 0, 15'h0001, 8'h00, 0, 2, 0);
      access(1, 0, 15'h0001, 8'h00, 0, 2, 0);
      // Write-through keeps the buffered byte coherent.
      access(1, 0, 15'h0005, 8'h00, 0, 1, 0);
      access(0, 1, 15'h0005, 8'hAB, 0, 1, 0);
      access(1, 0, 15'h0005, 8'h00, 0, 1, 0);
      chk("bus_mem_wr", 32'(bus_mem[5]), 32'hAB);
      // Timeout on a read, then a fresh bus read of the same address.
      access(1, 0, 15'h0010, 8'h00, 0, 0, 1);
      access(1, 0, 15'h0010, 8'h00, 0, 0, 0);
      // Simultaneous read and write: write only, error flagged.
      access(1, 1, 15'h0002, 8'h5A, 0, 1, 0);
      chk("bus_mem_rw", 32'(bus_mem[2]), 32'h5A);
      // Flush in the same cycle as a would-be hit forces a bus read.
      access(1, 0, 15'h0003, 8'h00, 0, 0, 0);
      access(1, 0, 15'h0003, 8'h00, 1, 0, 0);

      // Reset during a read wait, then the previously buffered byte must miss.
      access(1, 0, 15'h0020, 8'h00, 0, 0, 0);
      @(negedge clk);
      noack = 1'b1;
      bif.core_rd_en = 1'b1;
      bif.core_addr  = 15'h0030;
      repeat (3) @(negedge clk);
      chk("mid_req_up", 32'(bif.mem_req), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_req", 32'(bif.mem_req), 32'd0);
      chk("mid_rst_ready", 32'(bif.core_ready), 32'd0);
      chk("mid_rst_err", 32'(bif.bus_err), 32'd0);
      bif.core_rd_en = 1'b0;
      noack   = 1'b0;
      m_valid = 0;
      m_err   = 0;
      @(negedge clk);
      rst = 1'b1;
      access(1, 0, 15'h0020, 8'h00, 0, 1, 0);
      access(1, 0, 15'h0020, 8'h00, 0, 1, 0);

      do_reset();
      for (int k = 0; k < 300; k++) begin
         int  r;
         bit  rd;
         bit  wr;
         r  = int'($urandom_range(0, 99));
         rd = (r < 3) || (r >= 30);
         wr = (r < 30);
         access(rd, wr, ADDR_W'($urandom_range(0, 7)), 8'($urandom),
                ($urandom_range(0, 9) == 0), int'($urandom_range(0, 4)),
                ($urandom_range(0, 24) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/misao_mem_bridge.md
Name: misao_mem_bridge

Overview:
Byte-wide memory bridge between the MISA-O core's memory port and a handshaked external memory bus (req/ack, variable latency). The core reads each byte twice, once per nibble. A one-entry read buffer serves the second read of the same address with zero wait states. Writes go through to memory immediately, and an ack timeout sets a sticky error flag.

Parameters:
ADDR_W, 15, core and memory address width
DATA_W, 8, byte width
TIMEOUT, 15, max wait cycles for mem_ack before abort (1..255)
ERR_DATA, 8'h00, read data returned on a timed-out read

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-low reset (0 = reset)
core_rd_en  in  1  core read request, held until core_ready
core_wr_en  in  1  core write request, held until core_ready
core_addr  in  ADDR_W  byte address
core_wdata  in  DATA_W  write data
core_rdata  out  DATA_W  read data, valid when core_ready=1 on a read
core_ready  out  1  request complete this cycle
flush  in  1  invalidate read buffer
mem_req  out  1  bus request, registered
mem_we  out  1  1 = write, 0 = read, registered
mem_addr  out  ADDR_W  bus address, registered
mem_wdata  out  DATA_W  bus write data, registered
mem_rdata  in  DATA_W  bus read data, sampled when mem_ack=1
mem_ack  in  1  bus completes the transfer this cycle
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async), all cleared:
  - state=IDLE; buffer invalid; buf_addr=0; buf_data=0; timeout counter=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, bus_err=0.
  - core_ready=0, core_rdata=0.
  - Reset mid-transaction drops mem_req immediately; the transaction is lost.
- Read buffer:
  - Holds buf_addr, buf_data and a valid bit.
  - hit = valid && buf_addr==core_addr.
  - core_rdata = buf_data at all times.
- IDLE state, priority order:
  - Write: if core_wr_en, latch address/data onto the mem_* registers with mem_req=1, mem_we=1; next state WR_WAIT. Write wins over read.
  - Simultaneous core_rd_en and core_wr_en: perform the write and set bus_err.
  - Read hit: if core_rd_en and hit, core_ready=1 combinationally in the same cycle. No bus cycle; stay in IDLE.
  - Read miss: if core_rd_en and no hit, drive mem_req=1, mem_we=0, mem_addr=core_addr; next state RD_WAIT. Latency is 1 cycle plus the bus latency plus 1.
- RD_WAIT state:
  - Hold mem_req until mem_ack.
  - On ack, in the same edge: buf_data<=mem_rdata, buf_addr<=mem_addr, valid<=1, mem_req<=0; next state RESP.
- WR_WAIT state:
  - Hold mem_req until mem_ack.
  - On ack: if valid && buf_addr==mem_addr, then buf_data<=mem_wdata (keeps the buffer coherent).
  - mem_req<=0, mem_we<=0; next state RESP.
- RESP state:
  - core_ready=1 for exactly one cycle; next state IDLE.
  - Back-to-back reads of the same address then hit in the following cycle.
- Timeout:
  - The counter increments each cycle in RD_WAIT/WR_WAIT without ack, and clears when the state is left.
  - If the counter reaches TIMEOUT with no ack: mem_req<=0, bus_err<=1, buffer invalidated, buf_data<=ERR_DATA; next state RESP.
  - mem_ack in the same cycle as the timeout: ack wins, no error.
  - A late ack arriving in IDLE or RESP is ignored.
- bus_err stays set until reset.
- Request withdrawn: if the core drops its request mid-transaction, the bus transaction still completes. RESP still pulses core_ready; the core ignores it.
- flush:
  - In IDLE, valid<=0 at the next edge; a read in that same cycle is treated as a miss.
  - During a transaction, flush is recorded and applied after RESP, so a filled entry is invalidated.
- mem_addr and mem_wdata hold their last values when mem_req=0.

Test Plan:
- Two consecutive core reads of addr 0x0001 (mem[1]=0x35), ack latency 2 -> first read: core_ready at cycle 4, core_rdata=0x35, one mem_req burst. Second read: core_ready in the same cycle, no mem_req.
- Read addr 0x0005, then write 0xAB to 0x0005, then read 0x0005 -> write produces mem_we=1 with mem_wdata=0xAB; final read hits with 0xAB and no bus read.
- Memory never acks, TIMEOUT=15, read 0x0010 -> mem_req high for 15 cycles then 0; bus_err=1; core_ready pulses with core_rdata=0x00; next read of 0x0010 issues a new bus read.
- core_rd_en and core_wr_en both set at addr 0x0002, wdata 0x5A -> bus write of 0x5A to 0x0002 only; bus_err=1.
- Read 0x0003 (hit established), then flush=1 in IDLE with a read of 0x0003 in the same cycle -> treated as a miss; mem_req=1, mem_addr=0x0003.
- rst asserted low during RD_WAIT -> mem_req, core_ready and bus_err are 0 immediately; after release, a read of the same address misses.
